// File: rtl/frac_align_pipe_pkg.sv
// Shared helpers for the fraction aligner: sticky OR over the bits a right shift discards.
package frac_align_pipe_pkg;

  // OR of the low n bits of a (zero-extended) operand; n >= 64 covers every bit.
  function automatic logic shifted_out_or(input logic [63:0] bits, input int unsigned n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return |(bits & mask);
  endfunction

endpackage

// File: rtl/ShiftRightSticky.sv
// Logical right shift with sticky accumulation of every discarded bit.
module ShiftRightSticky
  import frac_align_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [WIDTH-1:0]       frac_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic                   sticky_i,
  output logic [WIDTH-1:0]       frac_c,
  output logic                   sticky_c
);

  always_comb begin
    frac_c   = '0;
    sticky_c = sticky_i;
    if (32'(shift_i) >= WIDTH) begin
      sticky_c = sticky_i | (|frac_i);
    end else begin
      frac_c   = frac_i >> shift_i;
      sticky_c = sticky_i | shifted_out_or(64'(frac_i), 32'(shift_i));
    end
  end

endmodule

// File: rtl/frac_align_pipe.sv
// Two-stage valid/ready fraction aligner: pad to datapath width, then right shift with sticky.
module frac_align_pipe
  import frac_align_pipe_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [IN_WIDTH-1:0]    in_frac,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [OUT_WIDTH-1:0]   out_frac,
  output logic                   out_sticky
);

  localparam int unsigned FW = OUT_WIDTH;
  localparam int unsigned SW = SHIFT_WIDTH;

  typedef struct packed {
    logic          sign;
    logic [FW-1:0] frac;
    logic [SW-1:0] shift;
    logic          sticky;
  } pad_beat_t;

  typedef struct packed {
    logic          sign;
    logic [FW-1:0] frac;
    logic          sticky;
  } aligned_beat_t;

  logic          v1_q, v1_d, v2_q, v2_d;
  pad_beat_t     s1_q, s1_d, pad_c;
  aligned_beat_t s2_q, s2_d, shift_c;
  logic          adv1_c, adv2_c;
  logic [FW-1:0] pad_frac_c;
  logic          pad_sticky_c;

  // Bring the MSB-aligned input onto the datapath width.
  generate
    if (IN_WIDTH < OUT_WIDTH) begin : g_pad
      assign pad_frac_c   = {in_frac, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
      assign pad_sticky_c = 1'b0;
    end else if (IN_WIDTH == OUT_WIDTH) begin : g_pass
      assign pad_frac_c   = in_frac;
      assign pad_sticky_c = 1'b0;
    end else begin : g_trunc
      assign pad_frac_c   = in_frac[IN_WIDTH-1 -: OUT_WIDTH];
      assign pad_sticky_c = |in_frac[IN_WIDTH-OUT_WIDTH-1:0];
    end
  endgenerate

  ShiftRightSticky #(
    .WIDTH      (FW),
    .SHIFT_WIDTH(SW)
  ) u_shift (
    .frac_i  (s1_q.frac),
    .shift_i (s1_q.shift),
    .sticky_i(s1_q.sticky),
    .frac_c  (shift_c.frac),
    .sticky_c(shift_c.sticky)
  );

  assign shift_c.sign = s1_q.sign;

  // Handshake and stage advance; stage 2 refills from stage 1 in the cycle it drains.
  always_comb begin
    pad_c  = '{sign: in_sign, frac: pad_frac_c, shift: in_shift, sticky: pad_sticky_c};
    adv2_c = !v2_q || out_ready;
    adv1_c = !v1_q || adv2_c;
    v1_d   = v1_q;
    s1_d   = s1_q;
    v2_d   = v2_q;
    s2_d   = s2_q;
    if (adv1_c) begin
      v1_d = in_valid;
      if (in_valid) s1_d = pad_c;
    end
    if (adv2_c) begin
      v2_d = v1_q;
      if (v1_q) s2_d = shift_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // Payload is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clock) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign in_ready   = adv1_c;
  assign out_valid  = v2_q;
  assign out_sign   = s2_q.sign;
  assign out_frac   = s2_q.frac;
  assign out_sticky = s2_q.sticky;

endmodule

// File: tb/tb_frac_align_pipe.sv
// Scoreboard bench for frac_align_pipe: wide-vector reference model, directed corners, random streaming.
module tb_frac_align_pipe;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 16;
  localparam int unsigned SW = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          in_valid, in_ready, in_sign;
  logic [IW-1:0] in_frac;
  logic [SW-1:0] in_shift;
  logic          out_valid, out_ready, out_sign, out_sticky;
  logic [OW-1:0] out_frac;

  logic          w_in_valid, w_in_ready, w_in_sign;
  logic [19:0]   w_in_frac;
  logic [SW-1:0] w_in_shift;
  logic          w_out_valid, w_out_ready, w_out_sign, w_out_sticky;
  logic [OW-1:0] w_out_frac;

  frac_align_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_frac(in_frac), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_frac(out_frac), .out_sticky(out_sticky)
  );

  frac_align_pipe #(.IN_WIDTH(20), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)) dut_wide (
    .clock(clock), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_sign(w_in_sign),
    .in_frac(w_in_frac), .in_shift(w_in_shift),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sign(w_out_sign),
    .out_frac(w_out_frac), .out_sticky(w_out_sticky)
  );

  typedef struct packed {
    logic          sign;
    logic [OW-1:0] frac;
    logic          sticky;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_in  = 0;
  int   n_out = 0;
  bit   stop_rand = 1'b0;
  bit   held = 1'b0;
  exp_t held_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Place the fraction at the top of a very wide word, shift, and read the window plus everything below it.
  function automatic exp_t ref_model(input logic s, input logic [IW-1:0] f, input logic [SW-1:0] sh);
    logic [127:0] ext;
    exp_t         r;
    ext      = {f, {(128-IW){1'b0}}} >> sh;
    r.sign   = s;
    r.frac   = ext[127 -: OW];
    r.sticky = |ext[127-OW:0];
    return r;
  endfunction

  // Monitor: records accepted beats, retires emitted beats, and watches held outputs.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset) begin
      sb_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_payload", 32'({out_sign, out_frac, out_sticky}), 32'(held_val));
      end
      held     = out_valid && !out_ready;
      held_val = '{sign: out_sign, frac: out_frac, sticky: out_sticky};
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_model(in_sign, in_frac, in_shift));
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: got frac %0h with nothing outstanding at %0t", out_frac, $time);
        end else begin
          e = sb_q.pop_front();
          n_out++;
          check("sb_sign", 32'(out_sign), 32'(e.sign));
          check("sb_frac", 32'(out_frac), 32'(e.frac));
          check("sb_sticky", 32'(out_sticky), 32'(e.sticky));
        end
      end
    end
  end

  task automatic send(input logic s, input logic [IW-1:0] f, input logic [SW-1:0] sh);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_frac  = f;
    in_shift = sh;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clock);
      done = in_ready && !reset;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready %0b expected 1", in_ready);
    end
  endtask

  task automatic directed(input string nm, input logic [IW-1:0] f, input logic [SW-1:0] sh,
                          input logic [OW-1:0] ef, input logic es);
    send(1'b0, f, sh);
    @(negedge clock);
    check({nm, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clock);
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_frac"}, 32'(out_frac), 32'(ef));
    check({nm, "_sticky"}, 32'(out_sticky), 32'(es));
    @(posedge clock);
    #1;
  endtask

  task automatic wide_beat(input string nm, input logic [19:0] f, input logic [SW-1:0] sh,
                           input logic [OW-1:0] ef, input logic es);
    bit done;
    done       = 1'b0;
    w_in_valid = 1'b1;
    w_in_sign  = 1'b1;
    w_in_frac  = f;
    w_in_shift = sh;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      done = w_in_ready;
      @(posedge clock);
      #1;
    end
    w_in_valid = 1'b0;
    check({nm, "_accept"}, 32'(done), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      done = w_out_valid;
    end
    check({nm, "_valid"}, 32'(done), 32'd1);
    check({nm, "_frac"}, 32'(w_out_frac), 32'(ef));
    check({nm, "_sticky"}, 32'(w_out_sticky), 32'(es));
    check({nm, "_sign"}, 32'(w_out_sign), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_frac     = '0;
    in_shift    = '0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_sign   = 1'b0;
    w_in_frac   = '0;
    w_in_shift  = '0;
    w_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Corner shifts, including past the datapath width and a zero fraction.
    directed("b5_s0", 8'hB5, 5'd0, 16'hB500, 1'b0);
    directed("b5_s4", 8'hB5, 5'd4, 16'h0B50, 1'b0);
    directed("b5_s12", 8'hB5, 5'd12, 16'h000B, 1'b1);
    directed("b5_s20", 8'hB5, 5'd20, 16'h0000, 1'b1);
    directed("zero_s20", 8'h00, 5'd20, 16'h0000, 1'b0);
    directed("b5_s16", 8'hB5, 5'd16, 16'h0000, 1'b1);

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sign = 1'b1; in_frac = 8'h81; in_shift = 5'd3;
    @(negedge clock);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_sign = 1'b0; in_frac = 8'h3C; in_shift = 5'd1;
    @(negedge clock);
    check("bp_b_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_sign = 1'b1; in_frac = 8'hF0; in_shift = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_c_blocked", 32'(in_ready), 32'd0);
      check("bp_a_shown", 32'(out_frac), 32'h1020);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_emit_a", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_emit_b", 32'(out_valid), 32'd1);
    check("bp_frac_b", 32'(out_frac), 32'h1E00);
    @(negedge clock);
    check("bp_emit_c", 32'(out_valid), 32'd1);
    check("bp_frac_c", 32'(out_frac), 32'h01E0);
    @(negedge clock);
    check("bp_drained", 32'(out_valid), 32'd0);
    @(posedge clock); #1;

    // Random streaming with random downstream stalls.
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
          end
          send(1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
               5'($urandom));
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clock); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      @(negedge clock);
      drained = (sb_q.size() == 0) && !out_valid;
    end
    check("stream_drained", 32'(drained), 32'd1);
    check("stream_count", 32'(n_out), 32'(n_in));

    // Reset with both stages full; a handshake during reset must be ignored.
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(1'b1, 8'hC3, 5'd2);
    send(1'b0, 8'h7E, 5'd5);
    @(negedge clock);
    check("rst_full_blocked", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = 1'b1; in_frac = 8'hFF; in_shift = 5'd1;
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    directed("post_rst", 8'h5A, 5'd2, 16'h1680, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clock); #1;

    // Input wider than the datapath: dropped low bits feed sticky.
    wide_beat("wide_abcd1", 20'hABCD1, 5'd0, 16'hABCD, 1'b1);
    wide_beat("wide_12340", 20'h12340, 5'd0, 16'h1234, 1'b0);
    wide_beat("wide_abcd0_s4", 20'hABCD0, 5'd4, 16'h0ABC, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
